addr_region_decoder: RTL and testbench
======================================

// Module: addr_region_decoder
// PURPOSE
//  Parametrised, sequential address decoder for the MIPS memory path. Compares each accepted
//  request address against N_REG inclusive regions and drives a registered one-hot chip select.
//  Adds a per-region wait-state count and a valid/ready/done handshake. Sits between the CPU
//  load/store port and the internal RAM / external memory.
// PARAMETERS
//  ADDR_W      32                           address width
//  N_REG       2                            number of regions (>=1)
//  BASE        {32'h0, 32'hD40}             packed N_REG*ADDR_W; region i at bits [i*ADDR_W +: ADDR_W]
//  LIMIT       {32'hFFFFFFFF, 32'h113F}     packed N_REG*ADDR_W; inclusive upper bound
//  WAIT        {4'd3, 4'd0}                 packed N_REG*4; wait states per region
//  DEFAULT_REG N_REG-1                      region selected on miss (macro absent)
// PORTS
//  clk         in   1              clock; all logic is rising-edge
//  rst         in   1              synchronous active-high reset
//  req_valid   in   1              request present
//  req_addr    in   ADDR_W         request address
//  req_ready   out  1              decoder can accept a request
//  cs          out  N_REG          one-hot chip select; registered
//  cs_idx      out  $clog2(N_REG)  encoded index of cs (0 when N_REG==1)
//  busy        out  1              request in progress
//  done        out  1              one-cycle completion pulse
//  err         out  1              miss flag; present only with ADDR_DEC_ERR_EN
//  fault_addr  out  ADDR_W         last missed address; present only with ADDR_DEC_ERR_EN
// BEHAVIOUR
//  Reset: state IDLE. req_ready, cs, cs_idx, busy, done, err, fault_addr all 0.
//   req_ready rises on the first clock edge after rst is low.
//  IDLE:   req_ready=1. req_valid & req_ready captures req_addr, clears req_ready, sets busy -> DECODE.
//  DECODE: one cycle. Hit i when BASE[i] <= addr <= LIMIT[i] (unsigned, both bounds inclusive).
//   On overlap the lowest index wins. A region with LIMIT < BASE never hits.
//   Registers cs/cs_idx and loads cnt=WAIT[idx]. cnt==0 -> RESP, otherwise -> WAITS.
//  WAITS:  cnt decrements each cycle; when cnt==1 -> RESP.
//  RESP:   done=1 for exactly one cycle. cs is held through RESP.
//   Next cycle: cs=0, busy=0, req_ready=1, state IDLE.
//  Latency: accept edge t -> done high in cycle t+2+WAIT[idx]. Back-to-back throughput is
//   one request per 3+WAIT cycles.
//  req_valid while req_ready=0 is ignored; requester holds until accepted.
//  rst mid-operation aborts the request: no done pulse; cs and busy are 0 after the reset edge.
//  cs is always one-hot or all-zero; never more than one bit set.
// CONFIGURATION
//  `ADDR_DEC_ERR_EN defined:
//   - Miss drives cs=0 and cs_idx=0, skips WAITS, and goes straight to RESP.
//   - err=1 in the RESP cycle only, coincident with done.
//   - fault_addr loads the missed address and holds it until the next miss or rst.
//  `ADDR_DEC_ERR_EN undefined:
//   - Miss selects DEFAULT_REG with WAIT[DEFAULT_REG].
//   - err and fault_addr ports do not exist.
// STRUCTURE
//  Package addr_dec_pkg: state localparams (IDLE, DECODE, WAITS, RESP); WAIT_W=4;
//   helper function to extract field i from a packed parameter vector.
//  Sub-module region_match (addr, base, limit -> hit): combinational, generated N_REG times.
//  Top level holds the FSM, wait counter, priority encoder and output registers.
// TESTING
//  1. rst held 3 cycles, then released -> all outputs 0 during reset; req_ready=1 on the
//     first cycle after release.
//  2. Addresses 0xD40, 0x113F, 0x1000 (defaults) -> cs=2'b01, done 2 cycles after accept;
//     0xD3F and 0x1140 -> cs=2'b10, done 5 cycles after accept (WAIT=3).
//  3. Overlapping regions, N_REG=3, addr inside regions 1 and 2 -> cs=3'b010 only.
//  4. ADDR_DEC_ERR_EN, region 1 = 0x0-0xFF, addr 0x2000 -> cs=0, done and err together
//     2 cycles after accept, fault_addr=0x2000.
//     Same setup without the macro -> cs selects DEFAULT_REG.
//  5. rst asserted during WAITS -> no done pulse; cs and busy are 0 after that edge;
//     the next request decodes normally.
//  6. req_valid held continuously with changing addr -> each address captured only when
//     req_ready=1; one done per accepted request; cs is never multi-hot.

Source files
------------

// File: rtl/addr_dec_pkg.sv
// -----------------------------------------------------------------------------
// addr_dec_pkg
//   Shared definitions for the MIPS memory-path address decoder.
//   - state_t     : decoder FSM states (IDLE, DECODE, WAITS, RESP)
//   - WAIT_W      : width of one per-region wait-state field
//   - get_field() : extracts field <idx> of <width> bits from a packed
//                   parameter vector (region i lives at [i*width +: width])
// -----------------------------------------------------------------------------
package addr_dec_pkg;

    // Width of one wait-state entry in the packed WAIT parameter.
    localparam int unsigned WAIT_W      = 4;

    // Working widths for get_field(). Packed parameter vectors are
    // zero-extended to VEC_MAX_W before slicing, and a single field may be up
    // to FIELD_MAX_W bits wide (covers 64-bit addresses).
    localparam int unsigned VEC_MAX_W   = 4096;
    localparam int unsigned FIELD_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAITS  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Pull field <idx> out of a packed vector. Intended for elaboration-time
    // use on parameters, so the wide shift folds away to constants.
    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [VEC_MAX_W-1:0]   shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = vec >> (idx * width);
        if (width >= FIELD_MAX_W) begin
            mask = '1;
        end else begin
            mask = (FIELD_MAX_W'(1) << width) - FIELD_MAX_W'(1);
        end
        return FIELD_MAX_W'(shifted) & mask;
    endfunction

endpackage : addr_dec_pkg

// File: rtl/addr_region_decoder_region_match.sv
// -----------------------------------------------------------------------------
// region_match
//   Combinational inclusive range compare for one decoder region.
//   Ports:
//     addr  in  ADDR_W  address under test
//     base  in  ADDR_W  lowest address of the region (inclusive)
//     limit in  ADDR_W  highest address of the region (inclusive)
//     hit   out 1       base <= addr <= limit, unsigned
//   A region whose limit is below its base can never satisfy both compares,
//   so it is effectively disabled without any extra logic.
// -----------------------------------------------------------------------------
module region_match #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              hit
);

    logic above_base;
    logic below_limit;

    assign above_base  = (addr >= base);
    assign below_limit = (addr <= limit);
    assign hit         = above_base && below_limit;

endmodule : region_match

// File: rtl/addr_region_decoder.sv
// -----------------------------------------------------------------------------
// addr_region_decoder
//   Sequential address decoder between the CPU load/store port and the
//   internal RAM / external memory. An accepted request address is compared
//   against N_REG inclusive regions; the winning region (lowest index on
//   overlap) gets a registered one-hot chip select, held for a per-region
//   number of wait states, then a one-cycle done pulse closes the request.
//
//   Optional feature macro: ADDR_DEC_ERR_EN
//     defined   : a miss raises err with done, skips wait states, drives
//                 cs = 0 and records the address in fault_addr.
//     undefined : a miss falls back to region DEFAULT_REG; no err/fault_addr.
//
//   Ports:
//     clk         in   1        rising-edge clock
//     rst         in   1        synchronous active-high reset
//     req_valid   in   1        request present
//     req_addr    in   ADDR_W   request address
//     req_ready   out  1        decoder can accept a request
//     cs          out  N_REG    one-hot chip select (registered)
//     cs_idx      out  IDX_W    encoded index of cs (0 when cs is 0)
//     busy        out  1        request in progress
//     err         out  1        miss flag, RESP cycle only (macro only)
//     fault_addr  out  ADDR_W   last missed address (macro only)
//     done        out  1        one-cycle completion pulse
//
//   Cycle sequence per request: IDLE (accept) -> DECODE -> WAITS x WAIT[i]
//   -> RESP (done) -> IDLE.
// -----------------------------------------------------------------------------
module addr_region_decoder
    import addr_dec_pkg::*;
#(
    parameter int unsigned                  ADDR_W      = 32,
    parameter int unsigned                  N_REG       = 2,
    parameter logic [N_REG*ADDR_W-1:0]      BASE        = {32'h0000_0000, 32'h0000_0D40},
    parameter logic [N_REG*ADDR_W-1:0]      LIMIT       = {32'hFFFF_FFFF, 32'h0000_113F},
    parameter logic [N_REG*WAIT_W-1:0]      WAIT        = {4'd3, 4'd0},
    parameter int                           DEFAULT_REG = N_REG - 1,
    localparam int unsigned                 IDX_W       = (N_REG > 1) ? $clog2(N_REG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic [N_REG-1:0]  cs,
    output logic [IDX_W-1:0]  cs_idx,
    output logic              busy,
`ifdef ADDR_DEC_ERR_EN
    output logic              err,
    output logic [ADDR_W-1:0] fault_addr,
`endif
    output logic              done
);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [WAIT_W-1:0]   cnt_reg;
    logic [N_REG-1:0]    cs_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                ready_reg;
    logic                busy_reg;
    logic                done_reg;

    // -------------------------------------------------------------------------
    // Region table and match vector
    // -------------------------------------------------------------------------
    logic [N_REG-1:0]    hit;
    logic [WAIT_W-1:0]   wait_tbl [N_REG];

    genvar gi;
    generate
        for (gi = 0; gi < N_REG; gi++) begin : g_region
            localparam logic [ADDR_W-1:0] BASE_I =
                ADDR_W'(get_field(VEC_MAX_W'(BASE), gi, ADDR_W));
            localparam logic [ADDR_W-1:0] LIMIT_I =
                ADDR_W'(get_field(VEC_MAX_W'(LIMIT), gi, ADDR_W));

            assign wait_tbl[gi] = WAIT_W'(get_field(VEC_MAX_W'(WAIT), gi, WAIT_W));

            region_match #(
                .ADDR_W (ADDR_W)
            ) u_match (
                .addr   (addr_reg),
                .base   (BASE_I),
                .limit  (LIMIT_I),
                .hit    (hit[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Priority encoder: scan from the top down so the lowest matching index
    // is the last one written and therefore wins on overlap.
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0]    hit_idx;
    logic                any_hit;

    always_comb begin
        hit_idx = '0;
        any_hit = 1'b0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = IDX_W'(i);
                any_hit = 1'b1;
            end
        end
    end

    // Region actually used for this request. On a miss this is the fallback
    // region; with the error feature enabled the miss path overrides it.
    logic [IDX_W-1:0]    sel_idx;
    logic [N_REG-1:0]    cs_dec;
    logic [WAIT_W-1:0]   wait_sel;
    logic                miss_skip;

    assign sel_idx  = any_hit ? hit_idx : IDX_W'(DEFAULT_REG);
    assign cs_dec   = N_REG'(1) << sel_idx;
    assign wait_sel = wait_tbl[sel_idx];

`ifdef ADDR_DEC_ERR_EN
    // A miss is reported rather than steered: no chip select, no wait states.
    assign miss_skip = !any_hit;
`else
    assign miss_skip = 1'b0;
`endif

    logic accept;
    assign accept = (state_reg == IDLE) && req_valid && ready_reg;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (miss_skip || (wait_sel == '0)) begin
                    state_next = RESP;
                end else begin
                    state_next = WAITS;
                end
            end
            WAITS: begin
                if (cnt_reg == WAIT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers. The handshake outputs are loaded from
    // state_next so they are registered yet line up with the state they
    // describe (done is high exactly while the FSM sits in RESP).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            cnt_reg   <= '0;
            cs_reg    <= '0;
            idx_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            ready_reg <= (state_next == IDLE);
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == RESP);

            if (accept) begin
                addr_reg <= req_addr;
            end

            case (state_reg)
                DECODE: begin
                    if (miss_skip) begin
                        cs_reg  <= '0;
                        idx_reg <= '0;
                    end else begin
                        cs_reg  <= cs_dec;
                        idx_reg <= sel_idx;
                    end
                    cnt_reg <= wait_sel;
                end
                WAITS: begin
                    cnt_reg <= cnt_reg - WAIT_W'(1);
                end
                RESP: begin
                    // Chip select is held through RESP and dropped as the
                    // decoder returns to IDLE.
                    cs_reg  <= '0;
                    idx_reg <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ADDR_DEC_ERR_EN
    logic              err_reg;
    logic [ADDR_W-1:0] fault_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg        <= 1'b0;
            fault_addr_reg <= '0;
        end else begin
            // A miss in DECODE always moves to RESP, so err coincides with done.
            err_reg <= (state_reg == DECODE) && !any_hit;
            if ((state_reg == DECODE) && !any_hit) begin
                fault_addr_reg <= addr_reg;
            end
        end
    end

    assign err        = err_reg;
    assign fault_addr = fault_addr_reg;
`endif

    assign req_ready = ready_reg;
    assign cs        = cs_reg;
    assign cs_idx    = idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule : addr_region_decoder

// File: tb/tb_addr_region_decoder.sv
// -----------------------------------------------------------------------------
// tb_addr_region_decoder
//   Three decoder instances share clock, reset and address:
//     inst 0 (a): default parameters
//     inst 1 (b): 3 regions, r0 inverted (never hits), r1/r2 overlap
//     inst 2 (c): 2 regions, r1 = 0x0-0xFF, used for miss handling
//   A table of directed vectors is applied one request at a time, followed
//   by hand-written reset-abort and continuous-valid sequences.
// -----------------------------------------------------------------------------
module tb_addr_region_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [2:0]  vld;

    always #5 clk = ~clk;

    // ---------------- instance a: defaults ----------------
    logic        ready_a, busy_a, done_a;
    logic [1:0]  cs_a;
    logic [0:0]  idx_a;
`ifdef ADDR_DEC_ERR_EN
    logic        err_a;
    logic [31:0] fa_a;
`endif

    addr_region_decoder u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (vld[0]),
        .req_addr   (addr),
        .req_ready  (ready_a),
        .cs         (cs_a),
        .cs_idx     (idx_a),
        .busy       (busy_a),
`ifdef ADDR_DEC_ERR_EN
        .err        (err_a),
        .fault_addr (fa_a),
`endif
        .done       (done_a)
    );

    // ---------------- instance b: overlap, N_REG=3 ----------------
    logic        ready_b, busy_b, done_b;
    logic [2:0]  cs_b;
    logic [1:0]  idx_b;
`ifdef ADDR_DEC_ERR_EN
    logic        err_b;
    logic [31:0] fa_b;
`endif

    addr_region_decoder #(
        .ADDR_W      (32),
        .N_REG       (3),
        .BASE        ({32'h0000_1800, 32'h0000_1000, 32'h0000_3000}),
        .LIMIT       ({32'h0000_27FF, 32'h0000_1FFF, 32'h0000_2000}),
        .WAIT        ({4'd0, 4'd2, 4'd1}),
        .DEFAULT_REG (2)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (vld[1]),
        .req_addr   (addr),
        .req_ready  (ready_b),
        .cs         (cs_b),
        .cs_idx     (idx_b),
        .busy       (busy_b),
`ifdef ADDR_DEC_ERR_EN
        .err        (err_b),
        .fault_addr (fa_b),
`endif
        .done       (done_b)
    );

    // ---------------- instance c: miss handling ----------------
    logic        ready_c, busy_c, done_c;
    logic [1:0]  cs_c;
    logic [0:0]  idx_c;
`ifdef ADDR_DEC_ERR_EN
    logic        err_c;
    logic [31:0] fa_c;
`endif

    addr_region_decoder #(
        .ADDR_W      (32),
        .N_REG       (2),
        .BASE        ({32'h0000_0000, 32'h0000_4000}),
        .LIMIT       ({32'h0000_00FF, 32'h0000_4FFF}),
        .WAIT        ({4'd2, 4'd1}),
        .DEFAULT_REG (1)
    ) u_dut_c (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (vld[2]),
        .req_addr   (addr),
        .req_ready  (ready_c),
        .cs         (cs_c),
        .cs_idx     (idx_c),
        .busy       (busy_c),
`ifdef ADDR_DEC_ERR_EN
        .err        (err_c),
        .fault_addr (fa_c),
`endif
        .done       (done_c)
    );

    // ---------------- selected-instance view ----------------
    int          cur;
    logic        s_ready, s_busy, s_done, s_err;
    logic [2:0]  s_cs;
    logic [1:0]  s_idx;
    logic [31:0] s_fa;

    always_comb begin
        s_ready = 1'b0;
        s_busy  = 1'b0;
        s_done  = 1'b0;
        s_err   = 1'b0;
        s_cs    = '0;
        s_idx   = '0;
        s_fa    = '0;
        case (cur)
            0: begin
                s_ready = ready_a; s_busy = busy_a; s_done = done_a;
                s_cs = {1'b0, cs_a}; s_idx = {1'b0, idx_a};
`ifdef ADDR_DEC_ERR_EN
                s_err = err_a; s_fa = fa_a;
`endif
            end
            1: begin
                s_ready = ready_b; s_busy = busy_b; s_done = done_b;
                s_cs = cs_b; s_idx = idx_b;
`ifdef ADDR_DEC_ERR_EN
                s_err = err_b; s_fa = fa_b;
`endif
            end
            2: begin
                s_ready = ready_c; s_busy = busy_c; s_done = done_c;
                s_cs = {1'b0, cs_c}; s_idx = {1'b0, idx_c};
`ifdef ADDR_DEC_ERR_EN
                s_err = err_c; s_fa = fa_c;
`endif
            end
            default: begin
            end
        endcase
    end

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int onehot_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // cs must never be multi-hot on any instance.
    always @(negedge clk) begin
        if ($countones(cs_a) > 1 || $countones(cs_b) > 1 || $countones(cs_c) > 1)
            onehot_errs <= onehot_errs + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One request on instance <inst>. Called and returns 2 time units after
    // a rising edge. Latency is counted from the accept cycle to the done cycle.
    task automatic do_req(input int inst, input logic [31:0] a,
                          output int lat, output logic [2:0] cs_d,
                          output logic [1:0] idx_d, output logic err_d,
                          output logic [31:0] fa_d, output logic [2:0] post);
        int acc;
        int guard;
        cur  = inst;
        addr = a;
        vld  = '0;
        vld[inst] = 1'b1;
        #1;
        guard = 0;
        while (!s_ready && guard < 40) begin
            @(posedge clk); #2; guard++;
        end
        acc = cyc;
        @(posedge clk); #2;
        vld = '0;
        while (!s_done && guard < 40) begin
            @(posedge clk); #2; guard++;
        end
        lat   = s_done ? (cyc - acc) : -1;
        cs_d  = s_cs;
        idx_d = s_idx;
        err_d = s_err;
        fa_d  = s_fa;
        @(posedge clk); #2;
        post = {s_ready, s_busy, (s_cs != 3'b000)};
    endtask

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [2:0]  cs;
        logic [1:0]  idx;
        int          lat;
        logic        err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic logic [2:0] model_a(input logic [31:0] a);
        return (a >= 32'h0000_0D40 && a <= 32'h0000_113F) ? 3'b001 : 3'b010;
    endfunction

    // global watchdog
    initial begin
        #300000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [2:0]  csd;
        logic [1:0]  idxd;
        logic        errd;
        logic [31:0] fad;
        logic [2:0]  post;
        logic [31:0] blist [5];
        logic [31:0] q [$];
        logic [31:0] qa;
        int          n_acc;
        int          n_done;
        int          abort_dones;

        // ---------- vector table ----------
        vecs[0]  = '{0, 32'h0000_0D40, 3'b001, 2'd0, 2, 1'b0};
        vecs[1]  = '{0, 32'h0000_113F, 3'b001, 2'd0, 2, 1'b0};
        vecs[2]  = '{0, 32'h0000_1000, 3'b001, 2'd0, 2, 1'b0};
        vecs[3]  = '{0, 32'h0000_0D3F, 3'b010, 2'd1, 5, 1'b0};
        vecs[4]  = '{0, 32'h0000_1140, 3'b010, 2'd1, 5, 1'b0};
        vecs[5]  = '{0, 32'hFFFF_FFFF, 3'b010, 2'd1, 5, 1'b0};
        vecs[6]  = '{0, 32'h0000_0000, 3'b010, 2'd1, 5, 1'b0};
        vecs[7]  = '{1, 32'h0000_1800, 3'b010, 2'd1, 4, 1'b0};
        vecs[8]  = '{1, 32'h0000_1FFF, 3'b010, 2'd1, 4, 1'b0};
        vecs[9]  = '{1, 32'h0000_2000, 3'b100, 2'd2, 2, 1'b0};
        vecs[10] = '{1, 32'h0000_1000, 3'b010, 2'd1, 4, 1'b0};
        vecs[11] = '{1, 32'h0000_27FF, 3'b100, 2'd2, 2, 1'b0};
        vecs[14] = '{2, 32'h0000_0080, 3'b010, 2'd1, 4, 1'b0};
        vecs[15] = '{2, 32'h0000_4000, 3'b001, 2'd0, 3, 1'b0};
        vecs[16] = '{2, 32'h0000_4FFF, 3'b001, 2'd0, 3, 1'b0};
`ifdef ADDR_DEC_ERR_EN
        vecs[12] = '{1, 32'h0000_3000, 3'b000, 2'd0, 2, 1'b1};
        vecs[13] = '{1, 32'h0000_0FFF, 3'b000, 2'd0, 2, 1'b1};
        vecs[17] = '{2, 32'h0000_2000, 3'b000, 2'd0, 2, 1'b1};
        vecs[18] = '{2, 32'h0000_5000, 3'b000, 2'd0, 2, 1'b1};
`else
        vecs[12] = '{1, 32'h0000_3000, 3'b100, 2'd2, 2, 1'b0};
        vecs[13] = '{1, 32'h0000_0FFF, 3'b100, 2'd2, 2, 1'b0};
        vecs[17] = '{2, 32'h0000_2000, 3'b010, 2'd1, 4, 1'b0};
        vecs[18] = '{2, 32'h0000_5000, 3'b010, 2'd1, 4, 1'b0};
`endif

        // ---------- reset ----------
        rst  = 1'b1;
        vld  = '0;
        addr = '0;
        cur  = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", ready_a, 1'b0);
        check("rst_cs",    cs_a,    2'b00);
        check("rst_idx",   idx_a,   1'b0);
        check("rst_busy",  busy_a,  1'b0);
        check("rst_done",  done_a,  1'b0);
`ifdef ADDR_DEC_ERR_EN
        check("rst_err",   err_a,   1'b0);
        check("rst_fa",    fa_a,    32'h0);
`endif
        rst = 1'b0;
        #1;
        check("rel_ready_before_edge", ready_a, 1'b0);
        @(posedge clk); #2;
        check("rel_ready_after_edge", ready_a, 1'b1);
        check("rel_ready_b", ready_b, 1'b1);
        $display("reset sequence ready=%b cs=%b busy=%b", ready_a, cs_a, busy_a);

        // ---------- table-driven vectors ----------
        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].inst, vecs[i].addr, lat, csd, idxd, errd, fad, post);
            $display("vec %0d inst=%0d addr=%h cs=%b idx=%0d lat=%0d err=%b",
                     i, vecs[i].inst, vecs[i].addr, csd, idxd, lat, errd);
            check($sformatf("v%0d_cs", i),   csd,  vecs[i].cs);
            check($sformatf("v%0d_idx", i),  idxd, vecs[i].idx);
            check($sformatf("v%0d_lat", i),  lat,  vecs[i].lat);
            check($sformatf("v%0d_post", i), post, 3'b100);
`ifdef ADDR_DEC_ERR_EN
            check($sformatf("v%0d_err", i),  errd, vecs[i].err);
            if (vecs[i].err)
                check($sformatf("v%0d_fault_addr", i), fad, vecs[i].addr);
`endif
        end

        // ---------- reset during WAITS ----------
        cur  = 0;
        addr = 32'h0000_0D3F;
        vld  = 3'b001;
        #1;
        check("abort_ready_pre", s_ready, 1'b1);
        @(posedge clk); #2;            // accepted, now DECODE
        vld = '0;
        @(posedge clk); #2;            // now WAITS
        check("abort_busy_in_waits", busy_a, 1'b1);
        check("abort_cs_in_waits",   cs_a,   2'b10);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("abort_cs_after_rst",   cs_a,   2'b00);
        check("abort_busy_after_rst", busy_a, 1'b0);
        abort_dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done_a) abort_dones++;
            @(posedge clk); #2;
        end
        check("abort_no_done", abort_dones, 0);
        $display("abort sequence dones_seen=%0d", abort_dones);
        do_req(0, 32'h0000_0D40, lat, csd, idxd, errd, fad, post);
        $display("post-abort request addr=00000d40 cs=%b lat=%0d", csd, lat);
        check("abort_next_cs",  csd, 3'b001);
        check("abort_next_lat", lat, 2);

        // ---------- continuous valid with changing address ----------
        blist[0] = 32'h0000_0D40;
        blist[1] = 32'h0000_0D3F;
        blist[2] = 32'h0000_1000;
        blist[3] = 32'h0000_1140;
        blist[4] = 32'h0000_113F;
        n_acc  = 0;
        n_done = 0;
        cur = 0;
        vld = 3'b001;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (s_done) begin
                n_done++;
                check("burst_pending", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    qa = q.pop_front();
                    $display("burst done addr=%h cs=%b", qa, s_cs);
                    check("burst_cs", s_cs, model_a(qa));
                end
            end
            addr = blist[i % 5];
            if (s_ready) begin
                q.push_back(addr);
                n_acc++;
            end
            @(posedge clk); #3;
        end
        vld = '0;
        for (int i = 0; i < 20; i++) begin
            if (s_done) begin
                n_done++;
                check("burst_pending", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    qa = q.pop_front();
                    $display("burst done addr=%h cs=%b", qa, s_cs);
                    check("burst_cs", s_cs, model_a(qa));
                end
            end
            @(posedge clk); #3;
        end
        check("burst_accepts_nonzero", (n_acc > 0), 1'b1);
        check("burst_done_count", n_done, n_acc);
        check("burst_queue_empty", q.size(), 0);

        check("cs_onehot", onehot_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_addr_region_decoder
